// File: rtl/writeback.sv
// Writeback stage: retires execute-stage results into the register file,
// maintains the architectural flag register and runs register-file clear sweeps.
module writeback #(
  parameter int DWIDTH = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [DWIDTH-1:0] stored_data,
  input  logic [DWIDTH-1:0] stored_instr,
  input  logic [DWIDTH-1:0] r_abs,
  input  logic [6:0]        RFlags,
  input  logic              reset_regs,
  input  logic              err_clr,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DWIDTH-1:0] rf_wdata,
  output logic [6:0]        flags_out,
  output logic              busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;
  localparam logic [4:0] LAST  = 5'(NREGS - 1);

  logic [1:0]        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [4:0]        dest_q, dest_d;
  logic [DWIDTH-1:0] rabs_q, rabs_d;
  logic              we_q, we_d;
  logic [4:0]        waddr_q, waddr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [6:0]        flags_q, flags_d;

  logic [4:0] op;
  logic [4:0] dst;
  logic       accept;
  logic       flag_ld;
  logic       unused_bits;

  assign op          = stored_instr[31:27];
  assign dst         = stored_instr[26:22];
  assign accept      = valid_in && (state_q == IDLE);
  assign flag_ld     = accept && (op != 5'd0);
  assign unused_bits = ^stored_instr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    rabs_d  = rabs_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept && reset_regs) begin
          state_d = CLEAR;
          cnt_d   = 5'd1;
          dest_d  = dst;
          rabs_d  = r_abs;
          we_d    = 1'b1;
          waddr_d = 5'd1;
          wdata_d = '0;
        end else if (accept && op != 5'd0 && dst != 5'd0) begin
          we_d    = 1'b1;
          waddr_d = dst;
          wdata_d = stored_data;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST) begin
          // Final write of the sweep; r0 stays architecturally zero
          state_d = FINAL;
          we_d    = (dest_q != 5'd0);
          waddr_d = dest_q;
          wdata_d = rabs_q;
        end else begin
          cnt_d   = cnt_q + 5'd1;
          we_d    = 1'b1;
          waddr_d = cnt_q + 5'd1;
          wdata_d = '0;
        end
      end
      FINAL: begin
        state_d = IDLE;
        cnt_d   = 5'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // Error bit is sticky: clear request loses against a new error
  always_comb begin
    flags_d    = flags_q;
    flags_d[6] = (flags_q[6] & ~err_clr) | (flag_ld & RFlags[6]);
    if (flag_ld) flags_d[5:0] = RFlags[5:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      dest_q  <= 5'd0;
      rabs_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= '0;
      flags_q <= 7'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
      rabs_q  <= rabs_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      flags_q <= flags_d;
    end
  end

  assign ready_out = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rf_we     = we_q;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = wdata_q;
  assign flags_out = flags_q;

endmodule

// File: tb/tb_writeback.sv
// Bench for writeback: directed scenarios then random traffic,
// checked against a cycle-position model of retire and sweep behaviour.
module tb_writeback;

  localparam int DW = 32;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic          ready_out;
  logic [DW-1:0] stored_data = '0;
  logic [DW-1:0] stored_instr = '0;
  logic [DW-1:0] r_abs = '0;
  logic [6:0]    RFlags = '0;
  logic          reset_regs = 1'b0;
  logic          err_clr = 1'b0;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [6:0]    flags_out;
  logic          busy;

  writeback #(.DWIDTH(DW), .NREGS(NR)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .ready_out(ready_out),
    .stored_data(stored_data), .stored_instr(stored_instr),
    .r_abs(r_abs), .RFlags(RFlags),
    .reset_regs(reset_regs), .err_clr(err_clr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flags_out(flags_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // model: m_pos = edges since sweep accept, -1 when not sweeping
  int            m_pos = -1;
  logic [4:0]    m_dest = '0;
  logic [DW-1:0] m_rabs = '0;
  logic [6:0]    m_flags = '0;
  logic          e_we = 1'b0;
  logic [4:0]    e_addr = '0;
  logic [DW-1:0] e_data = '0;
  bit            e_ad = 1'b1;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("ready", 64'(ready_out), 64'(m_pos < 0));
    chk("busy", 64'(busy), 64'(m_pos >= 0));
    chk("we", 64'(rf_we), 64'(e_we));
    chk("flags", 64'(flags_out), 64'(m_flags));
    if (e_ad) begin
      chk("waddr", 64'(rf_waddr), 64'(e_addr));
      chk("wdata", 64'(rf_wdata), 64'(e_data));
    end
  endtask

  task automatic tick();
    bit         acc;
    int         np;
    logic [4:0] op, d;
    logic       nwe;
    logic [4:0] na;
    logic [DW-1:0] nd;
    logic [6:0] nf;
    op  = stored_instr[31:27];
    d   = stored_instr[26:22];
    acc = valid_in && (m_pos < 0);
    nwe = 0; na = e_addr; nd = e_data;
    np  = m_pos;
    if (m_pos >= 0) begin
      np = m_pos + 1;
      if (np <= NR - 2) begin
        nwe = 1; na = 5'(np + 1); nd = '0;
      end else if (np == NR - 1) begin
        nwe = (m_dest != 0); na = m_dest; nd = m_rabs;
      end else np = -1;
    end else if (acc && reset_regs) begin
      np = 0; m_dest = d; m_rabs = r_abs;
      nwe = 1; na = 5'd1; nd = '0;
    end else if (acc && op != 0 && d != 0) begin
      nwe = 1; na = d; nd = stored_data;
    end
    nf = m_flags;
    nf[6] = m_flags[6] & ~err_clr;
    if (acc && op != 0) begin
      nf[5:0] = RFlags[5:0];
      nf[6] = nf[6] | RFlags[6];
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_pos = -1; m_flags = '0;
      e_we = 0; e_addr = '0; e_data = '0; e_ad = 1;
    end else begin
      m_pos = np; m_flags = nf;
      e_we = nwe; e_addr = na; e_data = nd; e_ad = nwe;
    end
    chk_all();
  endtask

  function automatic logic [DW-1:0] ins(int op, int d);
    logic [DW-1:0] r;
    r = '0;
    r[31:27] = 5'(op);
    r[26:22] = 5'(d);
    return r;
  endfunction

  int lowcnt;
  int hits;
  logic [6:0] fsave;

  initial begin
    #1;
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_addr", 64'(rf_waddr), 64'd0);
    chk("rst_data", 64'(rf_wdata), 64'd0);
    chk("rst_flags", 64'(flags_out), 64'd0);
    chk("rst_ready", 64'(ready_out), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();

    // normal write
    valid_in = 1; stored_instr = ins(3, 5); stored_data = 32'hDEADBEEF;
    RFlags = 7'h05;
    tick();
    chk("wr_we", 64'(rf_we), 64'd1);
    chk("wr_addr", 64'(rf_waddr), 64'd5);
    chk("wr_data", 64'(rf_wdata), 64'hDEADBEEF);
    valid_in = 0;
    tick();
    chk("wr_pulse", 64'(rf_we), 64'd0);

    // nop and r0 destination
    fsave = flags_out;
    valid_in = 1; stored_instr = ins(0, 5); RFlags = 7'h3F;
    tick();
    chk("nop_we", 64'(rf_we), 64'd0);
    chk("nop_flags", 64'(flags_out), 64'(fsave));
    stored_instr = ins(3, 0);
    tick();
    chk("r0_we", 64'(rf_we), 64'd0);

    // sticky error flag
    stored_instr = ins(1, 0); RFlags = 7'h40;
    tick();
    RFlags = 7'h02;
    tick();
    chk("sticky", 64'(flags_out), 64'h42);
    valid_in = 0; err_clr = 1;
    tick();
    chk("errclr", 64'(flags_out), 64'h02);
    valid_in = 1; RFlags = 7'h40;
    tick();
    chk("set_wins", 64'(flags_out[6]), 64'd1);
    err_clr = 0; valid_in = 0;
    tick();

    // sweep with back-pressured follow-up word
    valid_in = 1; reset_regs = 1; stored_instr = ins(2, 7);
    r_abs = 32'h12; RFlags = 7'h01;
    tick();
    reset_regs = 0; stored_instr = ins(3, 9); stored_data = 32'hAA;
    r_abs = 32'h99;
    lowcnt = 0; hits = 0;
    for (int i = 0; i < 100 && !ready_out; i++) begin
      lowcnt++;
      if (rf_we && rf_waddr == 5'd7 && rf_wdata == 32'h12) hits++;
      tick();
    end
    chk("sweep_len", 64'(lowcnt), 64'd32);
    chk("final_wr", 64'(hits), 64'd1);
    tick();
    chk("bp_we", 64'(rf_we), 64'd1);
    chk("bp_addr", 64'(rf_waddr), 64'd9);
    chk("bp_data", 64'(rf_wdata), 64'hAA);
    valid_in = 0;
    tick();
    chk("bp_once", 64'(rf_we), 64'd0);

    // reset in the middle of a sweep
    valid_in = 1; reset_regs = 1; stored_instr = ins(2, 7);
    tick();
    valid_in = 0; reset_regs = 0;
    for (int i = 0; i < 60 && m_pos < 9; i++) tick();
    chk("at10", 64'(rf_waddr), 64'd10);
    #2 rst = 1;
    #1;
    chk("ar_we", 64'(rf_we), 64'd0);
    chk("ar_addr", 64'(rf_waddr), 64'd0);
    chk("ar_data", 64'(rf_wdata), 64'd0);
    chk("ar_flags", 64'(flags_out), 64'd0);
    chk("ar_ready", 64'(ready_out), 64'd1);
    chk("ar_busy", 64'(busy), 64'd0);
    tick();
    @(negedge clk);
    rst = 0;
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rf_we) hits++;
    end
    chk("no_resume", 64'(hits), 64'd0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      valid_in     = ($urandom_range(0, 3) != 0);
      stored_instr = $urandom;
      if ($urandom_range(0, 5) == 0) stored_instr[31:27] = 5'd0;
      if ($urandom_range(0, 5) == 0) stored_instr[26:22] = 5'd0;
      stored_data  = $urandom;
      r_abs        = $urandom;
      RFlags       = 7'($urandom);
      reset_regs   = ($urandom_range(0, 40) == 0);
      err_clr      = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 SHALL provide parameter DWIDTH, default 32, data/instruction width.
REQ-002 SHALL provide parameter NREGS, default 32, register-file depth; address width is 5 bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port valid_in  input  1  upstream execute-stage word valid.
REQ-006 SHALL have port ready_out  output  1  block can accept a word this cycle.
REQ-007 SHALL have port stored_data  input  DWIDTH  result from execute stage.
REQ-008 SHALL have port stored_instr  input  DWIDTH  instruction; opcode = [31:27], dest = [26:22].
REQ-009 SHALL have port r_abs  input  DWIDTH  value written to dest after a clear sweep.
REQ-010 SHALL have port RFlags  input  7  status flags from execute stage.
REQ-011 SHALL have port reset_regs  input  1  request register-file clear sweep.
REQ-012 SHALL have port err_clr  input  1  clears sticky error flag.
REQ-013 SHALL have port rf_we  output  1  register-file write enable.
REQ-014 SHALL have port rf_waddr  output  5  register-file write address.
REQ-015 SHALL have port rf_wdata  output  DWIDTH  register-file write data.
REQ-016 SHALL have port flags_out  output  7  architectural flag register.
REQ-017 SHALL have port busy  output  1  high while a clear sweep is in progress.

Function
REQ-018 SHALL use FSM states IDLE, CLEAR, FINAL; ready_out = (state == IDLE); busy = (state != IDLE).
REQ-019 SHALL accept a word on a rising edge where valid_in && ready_out; no accept in CLEAR/FINAL, and upstream holds its word.
REQ-020 On accept with reset_regs=0, opcode!=0, dest!=0: SHALL register rf_we=1, rf_waddr=dest, rf_wdata=stored_data, visible the cycle after accept (latency 1).
REQ-021 On accept with reset_regs=0 and opcode==0 or dest==0: SHALL register rf_we=0; FSM stays IDLE.
REQ-022 rf_we SHALL be 0 in every cycle following an edge with no write to issue (single-cycle pulse per write).
REQ-023 On accept with opcode!=0: SHALL load flags_out[5:0] <= RFlags[5:0], flags_out[6] <= flags_out[6] | RFlags[6] (sticky).
REQ-024 err_clr SHALL clear flags_out[6] at next edge; if RFlags[6]=1 is accepted in the same edge, set wins.
REQ-025 On accept with reset_regs=1: SHALL latch dest and r_abs, enter CLEAR, issue rf_we=1, rf_waddr=1, rf_wdata=0 at that edge.
REQ-026 In CLEAR: SHALL increment the sweep counter each edge, writing 0 to addresses 1..NREGS-1 inclusive (NREGS-1 consecutive write cycles, dest included); address 0 never written.
REQ-027 After the write to NREGS-1: SHALL enter FINAL and issue rf_we=1, rf_waddr=latched dest, rf_wdata=latched r_abs; if dest==0, rf_we=0 for that cycle.
REQ-028 From FINAL: SHALL return to IDLE at the next edge with rf_we=0; ready_out high from then on.
REQ-029 Sweep total: accept at edge N -> zero writes after edges N..N+NREGS-2, final write after N+NREGS-1, ready_out=1 after N+NREGS.
REQ-030 Flag update of REQ-023 SHALL also apply to a reset_regs accept.
REQ-031 Changes on stored_* / r_abs during CLEAR/FINAL SHALL NOT affect the sweep or final write.

Reset
REQ-032 rst=1 SHALL immediately force state=IDLE, counter=0, rf_we=0, rf_waddr=0, rf_wdata=0, flags_out=0, ready_out=1, busy=0, independent of clk.
REQ-033 rst asserted mid-sweep SHALL abort the sweep with no further writes; no resume after release.

Verification
REQ-034 Normal write: valid, opcode=3, dest=5, data=0xDEADBEEF -> next cycle rf_we=1, addr=5, wdata=0xDEADBEEF; cycle after rf_we=0.
REQ-035 Nop/r0: opcode=0 dest=5, then opcode=3 dest=0 -> rf_we never 1; flags_out unchanged for nop.
REQ-036 Sweep: reset_regs=1, dest=7, r_abs=0x12 (NREGS=32) -> 31 writes of 0 to addr 1..31, then addr 7 = 0x12; ready_out low 32 cycles, high thereafter.
REQ-037 Sticky error: accept RFlags=7'h40 then RFlags=7'h02 -> flags_out=7'h42; err_clr -> 7'h02; err_clr with RFlags[6]=1 accepted -> bit 6 stays 1.
REQ-038 Back-pressure: valid_in held high with new word during sweep -> not accepted until ready_out=1, then written once.
REQ-039 Reset mid-sweep: rst at sweep address 10 -> rf_we=0 immediately, outputs zero, ready_out=1, no final write.
